qbu_verify_rx_det: RTL and testbench
====================================

QBU_VERIFY_RX_DET -- requirements
Module: qbu_verify_rx_det

Interface
REQ-001 Parameter FRAME_LEN, default 60, required byte count of an mPacket verify/response payload.
REQ-002 Parameter SMD_V, default 8'h07, SMD code of a verify mPacket.
REQ-003 Parameter SMD_R, default 8'h19, SMD code of a response mPacket.
REQ-004 i_clk  in  1  single clock, 125 MHz; all logic on rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-low.
REQ-006 i_det_enable  in  1  detection enable; 0 = ignore all input.
REQ-007 i_rx_data  in  8  received payload byte.
REQ-008 i_rx_valid  in  1  byte valid.
REQ-009 i_rx_last  in  1  final byte of mPacket, qualified by i_rx_valid.
REQ-010 i_rx_smd  in  8  SMD code of mPacket.
REQ-011 i_rx_smd_valid  in  1  i_rx_smd valid; asserted with first byte only.
REQ-012 o_rx_ready  out  1  constant 1; no backpressure.
REQ-013 o_qbu_verify_valid  out  1  one-cycle pulse: valid verify mPacket received.
REQ-014 o_qbu_response_valid  out  1  one-cycle pulse: valid response mPacket received.
REQ-015 o_verify_rx_cnt  out  16  count of valid verify mPackets.
REQ-016 o_response_rx_cnt  out  16  count of valid response mPackets.
REQ-017 o_err_frame_cnt  out  16  count of malformed verify/response mPackets.

Function
REQ-018 FSM states SHALL be IDLE, RECV, DROP; one-hot encoding.
REQ-019 IDLE->RECV when i_det_enable & i_rx_valid & i_rx_smd_valid & (i_rx_smd==SMD_V or SMD_R); latch frame type; this byte counts as byte 1.
REQ-020 Other SMD codes in IDLE SHALL be ignored; no counter change.
REQ-021 RECV: each valid byte increments 7-bit byte count (saturates at 127); nonzero byte sets zero-error flag.
REQ-022 RECV, valid byte with i_rx_last: frame good iff count (including this byte)==FRAME_LEN and no nonzero byte; -> IDLE.
REQ-023 Good frame: matching pulse and counter increment in cycle after last byte (latency 1); otherwise o_err_frame_cnt +1 in same cycle.
REQ-024 RECV, valid byte without last and count reaching FRAME_LEN+1: -> DROP; error counted once on entry.
REQ-025 DROP: discard bytes until valid last -> IDLE; no further count.
REQ-026 i_rx_smd_valid & i_rx_valid in RECV or DROP (missing last): current frame counts as error (RECV only) and new frame starts per REQ-019 in same cycle.
REQ-027 Single-byte frame (smd_valid & last together) SHALL be evaluated per REQ-022 immediately; from IDLE -> IDLE.
REQ-028 i_det_enable deassert: FSM -> IDLE next cycle, in-flight frame abandoned, no pulse, no error count.
REQ-029 Counters SHALL saturate at 16'hFFFF.
REQ-030 o_qbu_verify_valid and o_qbu_response_valid SHALL never assert together.
REQ-031 All outputs registered except o_rx_ready.

Reset
REQ-032 i_rst low at a clock edge: FSM IDLE, byte count 0, flags 0, pulses 0, all three counters 0.
REQ-033 Reset mid-frame: frame abandoned, no pulse, no error count; bytes until next SMD ignored.

Structure
REQ-034 Shared package holds SMD_V, SMD_R, FRAME_LEN defaults and FSM state encodings, shared with the verify transmit FSM.
REQ-035 No sub-module; single flat module.

Verification
REQ-036 SMD 07, 60 zero bytes, last on byte 60 -> o_qbu_verify_valid pulse 1 cycle after, o_verify_rx_cnt=1.
REQ-037 SMD 19, 60 zero bytes, byte 30 = 8'h55 -> no pulse, o_err_frame_cnt=1.
REQ-038 SMD 07, 64 zero bytes -> DROP entered at byte 61, o_err_frame_cnt=1, no pulse; following good SMD 19 frame -> response pulse.
REQ-039 SMD 07, 20 bytes, then new SMD 19 + 60 zero bytes -> err=1, o_qbu_response_valid pulse, response_cnt=1.
REQ-040 SMD 0x2A frame of 60 zeros -> no pulse, all counters 0; i_det_enable=0 during good SMD 07 frame -> no pulse.
REQ-041 i_rst low at byte 30 of good frame -> all outputs 0, no pulse after release.

Source files
------------

// File: rtl/qbu_verify_rx_det_pkg.sv
// Shared constants, state encodings and saturating helpers for the
// frame-preemption verify/response handshake (rx detector and tx FSM).
package qbu_verify_rx_det_pkg;

  localparam int         FRAME_LEN_DEF = 60;
  localparam logic [7:0] SMD_V_DEF     = 8'h07;
  localparam logic [7:0] SMD_R_DEF     = 8'h19;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_RECV = 3'b010,
    ST_DROP = 3'b100
  } vfy_state_t;

  function automatic logic [15:0] sat_add16(
    input logic [15:0] a,
    input logic [1:0]  b
  );
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [6:0] sat_inc7(input logic [6:0] a);
    return (a == 7'h7F) ? a : a + 7'd1;
  endfunction

endpackage

// File: rtl/qbu_verify_rx_det.sv
// Detects verify/response mPackets on the receive path, checks length
// and all-zero payload, and reports pulses plus saturating counters.
module qbu_verify_rx_det
  import qbu_verify_rx_det_pkg::*;
#(
  parameter int         FRAME_LEN = FRAME_LEN_DEF,
  parameter logic [7:0] SMD_V     = SMD_V_DEF,
  parameter logic [7:0] SMD_R     = SMD_R_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_det_enable,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_rx_last,
  input  logic [7:0]  i_rx_smd,
  input  logic        i_rx_smd_valid,
  output logic        o_rx_ready,
  output logic        o_qbu_verify_valid,
  output logic        o_qbu_response_valid,
  output logic [15:0] o_verify_rx_cnt,
  output logic [15:0] o_response_rx_cnt,
  output logic [15:0] o_err_frame_cnt
);

  localparam logic [6:0] LEN7   = 7'(FRAME_LEN);
  localparam logic [6:0] LEN7P1 = 7'(FRAME_LEN + 1);

  vfy_state_t state;
  logic [6:0] byte_cnt;
  logic       nz_err;
  logic       is_resp;

  logic       first;
  logic       start;
  logic       cont;
  logic [6:0] cnt_inc;
  logic       nz_inc;
  logic       abort_err;
  logic       frame_end;
  logic       end_ok;
  logic       end_resp;
  logic       drop_err;
  logic [1:0] err_inc;
  logic       good_v;
  logic       good_r;

  assign o_rx_ready = 1'b1;

  always_comb begin
    first     = i_det_enable & i_rx_valid & i_rx_smd_valid;
    start     = first & ((i_rx_smd == SMD_V) | (i_rx_smd == SMD_R));
    cont      = i_det_enable & i_rx_valid & ~i_rx_smd_valid
              & (state == ST_RECV);
    cnt_inc   = sat_inc7(byte_cnt);
    nz_inc    = nz_err | (|i_rx_data);
    // a new SMD while still receiving means the old frame lost its last
    abort_err = first & (state == ST_RECV);
    frame_end = (start | cont) & i_rx_last;
    end_ok    = start ? ((LEN7 == 7'd1) && (i_rx_data == 8'd0))
                      : ((cnt_inc == LEN7) && !nz_inc);
    end_resp  = start ? (i_rx_smd == SMD_R) : is_resp;
    drop_err  = cont & ~i_rx_last & (cnt_inc == LEN7P1);
    err_inc   = {1'b0, abort_err}
              + {1'b0, frame_end & ~end_ok}
              + {1'b0, drop_err};
    good_v    = frame_end & end_ok & ~end_resp;
    good_r    = frame_end & end_ok & end_resp;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state                <= ST_IDLE;
      byte_cnt             <= 7'd0;
      nz_err               <= 1'b0;
      is_resp              <= 1'b0;
      o_qbu_verify_valid   <= 1'b0;
      o_qbu_response_valid <= 1'b0;
      o_verify_rx_cnt      <= 16'd0;
      o_response_rx_cnt    <= 16'd0;
      o_err_frame_cnt      <= 16'd0;
    end else begin
      o_qbu_verify_valid   <= good_v;
      o_qbu_response_valid <= good_r;
      o_verify_rx_cnt      <= sat_add16(o_verify_rx_cnt, {1'b0, good_v});
      o_response_rx_cnt    <= sat_add16(o_response_rx_cnt, {1'b0, good_r});
      o_err_frame_cnt      <= sat_add16(o_err_frame_cnt, err_inc);
      if (!i_det_enable) begin
        state    <= ST_IDLE;
        byte_cnt <= 7'd0;
        nz_err   <= 1'b0;
      end else if (i_rx_valid && i_rx_smd_valid) begin
        if (start && !i_rx_last) begin
          state    <= ST_RECV;
          byte_cnt <= 7'd1;
          nz_err   <= |i_rx_data;
          is_resp  <= (i_rx_smd == SMD_R);
        end else begin
          state    <= ST_IDLE;
          byte_cnt <= 7'd0;
          nz_err   <= 1'b0;
        end
      end else if (i_rx_valid) begin
        case (state)
          ST_IDLE: ;
          ST_RECV: begin
            if (i_rx_last) begin
              state    <= ST_IDLE;
              byte_cnt <= 7'd0;
              nz_err   <= 1'b0;
            end else if (cnt_inc == LEN7P1) begin
              state <= ST_DROP;
            end else begin
              byte_cnt <= cnt_inc;
              nz_err   <= nz_inc;
            end
          end
          ST_DROP: begin
            if (i_rx_last) begin
              state    <= ST_IDLE;
              byte_cnt <= 7'd0;
              nz_err   <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qbu_verify_rx_det.sv
// Directed-vector bench for qbu_verify_rx_det with hand-computed
// expected counter values and pulse tallies.
module tb_qbu_verify_rx_det;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_det_enable = 1'b0;
  logic [7:0]  i_rx_data = 8'd0;
  logic        i_rx_valid = 1'b0;
  logic        i_rx_last = 1'b0;
  logic [7:0]  i_rx_smd = 8'd0;
  logic        i_rx_smd_valid = 1'b0;
  logic        o_rx_ready;
  logic        o_qbu_verify_valid;
  logic        o_qbu_response_valid;
  logic [15:0] o_verify_rx_cnt;
  logic [15:0] o_response_rx_cnt;
  logic [15:0] o_err_frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int v_pulses = 0;
  int r_pulses = 0;
  int both_seen = 0;

  qbu_verify_rx_det dut (
    .i_clk                (i_clk),
    .i_rst                (i_rst),
    .i_det_enable         (i_det_enable),
    .i_rx_data            (i_rx_data),
    .i_rx_valid           (i_rx_valid),
    .i_rx_last            (i_rx_last),
    .i_rx_smd             (i_rx_smd),
    .i_rx_smd_valid       (i_rx_smd_valid),
    .o_rx_ready           (o_rx_ready),
    .o_qbu_verify_valid   (o_qbu_verify_valid),
    .o_qbu_response_valid (o_qbu_response_valid),
    .o_verify_rx_cnt      (o_verify_rx_cnt),
    .o_response_rx_cnt    (o_response_rx_cnt),
    .o_err_frame_cnt      (o_err_frame_cnt)
  );

  always #4 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_qbu_verify_valid)   v_pulses <= v_pulses + 1;
    if (o_qbu_response_valid) r_pulses <= r_pulses + 1;
    if (o_qbu_verify_valid && o_qbu_response_valid)
      both_seen <= both_seen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    i_rx_valid     = 1'b0;
    i_rx_smd_valid = 1'b0;
    i_rx_last      = 1'b0;
    i_rx_data      = 8'd0;
  endtask

  // n bytes; SMD on byte 1 if with_smd; last on byte n if with_last
  task automatic send(input logic [7:0] smd, input int n,
                      input bit with_smd, input bit with_last,
                      input int bad_pos, input logic [7:0] bad_val);
    for (int i = 1; i <= n; i++) begin
      @(negedge i_clk);
      i_rx_valid     = 1'b1;
      i_rx_smd_valid = with_smd && (i == 1);
      i_rx_smd       = smd;
      i_rx_data      = (i == bad_pos) ? bad_val : 8'd0;
      i_rx_last      = with_last && (i == n);
    end
    @(negedge i_clk);
    idle_in();
  endtask

  task automatic settle();
    repeat (2) @(negedge i_clk);
    #1;
  endtask

  task automatic chk_cnts(input string tag, input int v, input int r,
                          input int e);
    chk({tag, "_vcnt"}, 32'(o_verify_rx_cnt), 32'(v));
    chk({tag, "_rcnt"}, 32'(o_response_rx_cnt), 32'(r));
    chk({tag, "_err"}, 32'(o_err_frame_cnt), 32'(e));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_ready", 32'(o_rx_ready), 32'd1);
    chk("rst_vpulse", 32'(o_qbu_verify_valid), 32'd0);
    chk("rst_rpulse", 32'(o_qbu_response_valid), 32'd0);
    chk_cnts("rst", 0, 0, 0);
    i_rst = 1'b1;
    i_det_enable = 1'b1;

    // good verify frame, pulse one cycle after last byte
    send(8'h07, 60, 1, 1, 0, 8'h00);
    chk("good_v_pulse", 32'(o_qbu_verify_valid), 32'd1);
    chk("good_v_rpulse", 32'(o_qbu_response_valid), 32'd0);
    chk("good_v_cnt", 32'(o_verify_rx_cnt), 32'd1);
    @(negedge i_clk);
    chk("good_v_pulse_end", 32'(o_qbu_verify_valid), 32'd0);

    // nonzero payload byte
    send(8'h19, 60, 1, 1, 30, 8'h55);
    settle();
    chk_cnts("nz", 1, 0, 1);

    // overlong frame: drop entered at byte 61
    send(8'h07, 61, 1, 0, 0, 8'h00);
    chk("drop_err_at61", 32'(o_err_frame_cnt), 32'd2);
    send(8'h07, 3, 0, 1, 0, 8'h00);
    settle();
    chk_cnts("drop", 1, 0, 2);
    send(8'h19, 60, 1, 1, 0, 8'h00);
    chk("after_drop_rpulse", 32'(o_qbu_response_valid), 32'd1);
    settle();
    chk_cnts("after_drop", 1, 1, 2);

    // missing last, interrupted by new response frame
    send(8'h07, 20, 1, 0, 0, 8'h00);
    send(8'h19, 60, 1, 1, 0, 8'h00);
    chk("restart_rpulse", 32'(o_qbu_response_valid), 32'd1);
    settle();
    chk_cnts("restart", 1, 2, 3);

    // foreign SMD ignored
    send(8'h2A, 60, 1, 1, 0, 8'h00);
    settle();
    chk_cnts("foreign", 1, 2, 3);

    // enable dropped mid-frame
    send(8'h07, 30, 1, 0, 0, 8'h00);
    i_det_enable = 1'b0;
    @(negedge i_clk);
    i_det_enable = 1'b1;
    send(8'h07, 30, 0, 1, 0, 8'h00);
    settle();
    chk_cnts("disable", 1, 2, 3);

    // one byte short, then single-byte frame
    send(8'h07, 59, 1, 1, 0, 8'h00);
    settle();
    chk("short_err", 32'(o_err_frame_cnt), 32'd4);
    send(8'h07, 1, 1, 1, 0, 8'h00);
    settle();
    chk("single_err", 32'(o_err_frame_cnt), 32'd5);

    // reset mid-frame
    send(8'h07, 30, 1, 0, 0, 8'h00);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("midrst_vpulse", 32'(o_qbu_verify_valid), 32'd0);
    chk_cnts("midrst", 0, 0, 0);
    i_rst = 1'b1;
    send(8'h07, 30, 0, 1, 0, 8'h00);
    settle();
    chk_cnts("postrst", 0, 0, 0);

    send(8'h19, 60, 1, 1, 0, 8'h00);
    settle();
    chk_cnts("recover", 0, 1, 0);

    chk("tally_v", 32'(v_pulses), 32'd1);
    chk("tally_r", 32'(r_pulses), 32'd3);
    chk("tally_both", 32'(both_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
